// File: rtl/cpu_state_dumper_if.sv
// cpu_state_dumper_if
//   Valid/ready stream carrying the words of a halt dump.
//   The master (the dumper) drives valid/kind/index/data/last.
//   The slave (the sink) drives ready.
//   valid  : word present
//   ready  : sink accepts the word
//   kind   : 0 = memory word, 1 = register (or checksum) word
//   index  : memory address, or register index zero-extended
//   data   : word value
//   last   : final word of the dump
interface cpu_state_dumper_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 8
);
    logic              valid;
    logic              ready;
    logic              kind;
    logic [IDX_W-1:0]  index;
    logic [DATA_W-1:0] data;
    logic              last;

    modport master (output valid, kind, index, data, last, input ready);
    modport slave  (input valid, kind, index, data, last, output ready);
endinterface

// File: rtl/cpu_state_dumper.sv
// cpu_state_dumper
//   On a 1->0 edge of do_halt, reads a window of data memory, then the
//   register file, and streams every word out over the dump interface.
//   Build option: define DUMP_CHECKSUM_EN to append one checksum word
//   (sum of all emitted words mod 2^DATA_W) after the last register.
// Ports:
//   CLK        system clock, posedge
//   rst        asynchronous active-low reset
//   do_halt    CPU halt flag, active-low; falling edge requests a dump
//   mem_raddr  memory read address (data expected the following cycle)
//   mem_rdata  memory read data
//   reg_raddr  register file read address (data expected the following cycle)
//   reg_rdata  register file read data
//   dump       output word stream (master side)
//   dump_busy  dump in progress
//   dump_done  dump finished; sticky until do_halt returns high
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | armed, waiting for a falling edge of do_halt
// READ  | present the current index on the selected read port
// WAIT  | capture read data into the output word, raise valid
// EMIT  | hold the word until accepted, then advance the index
// DONE  | dump complete; wait for do_halt high to re-arm
module cpu_state_dumper #(
    parameter int DATA_W         = 16,
    parameter int MEM_ADDR_W     = 8,
    parameter int MEM_DUMP_BASE  = 0,
    parameter int MEM_DUMP_DEPTH = 16,
    parameter int NUM_REGS       = 8,
    parameter int REG_ADDR_W     = 3
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  do_halt,
    output logic [MEM_ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [REG_ADDR_W-1:0] reg_raddr,
    input  logic [DATA_W-1:0]     reg_rdata,
    cpu_state_dumper_if.master    dump,
    output logic                  dump_busy,
    output logic                  dump_done
);

    localparam int CNT_W = (MEM_DUMP_DEPTH > 0) ? $clog2(MEM_DUMP_DEPTH + 1) : 1;
    localparam logic [REG_ADDR_W-1:0] REG_LAST = REG_ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {IDLE, READ, WAIT, EMIT, DONE} state_t;
    typedef enum logic [1:0] {PH_MEM, PH_REG, PH_CSUM} phase_t;

    state_t                state, state_nxt;
    phase_t                phase;
    logic                  do_halt_q;
    logic [MEM_ADDR_W-1:0] mem_idx;
    logic [CNT_W-1:0]      mem_left;
    logic [REG_ADDR_W-1:0] reg_idx;
    logic                  start;
    logic                  hs;
`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0]     acc;
`endif

    assign start = do_halt_q & ~do_halt;
    assign hs    = dump.valid & dump.ready;

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The registered last flag is the single source of "dump ends here",
    // whether the final word is the last register or the checksum.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = READ;
            READ: state_nxt = WAIT;
            WAIT: state_nxt = EMIT;
            EMIT: if (hs) state_nxt = dump.last ? DONE : READ;
            DONE: if (do_halt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            do_halt_q  <= 1'b1;
            phase      <= PH_MEM;
            mem_idx    <= '0;
            mem_left   <= '0;
            reg_idx    <= '0;
            mem_raddr  <= '0;
            reg_raddr  <= '0;
            dump.valid <= 1'b0;
            dump.kind  <= 1'b0;
            dump.index <= '0;
            dump.data  <= '0;
            dump.last  <= 1'b0;
            dump_busy  <= 1'b0;
            dump_done  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            acc        <= '0;
`endif
        end else begin
            do_halt_q <= do_halt;
            case (state)
                IDLE: begin
                    if (start) begin
                        phase     <= (MEM_DUMP_DEPTH == 0) ? PH_REG : PH_MEM;
                        mem_idx   <= MEM_ADDR_W'(MEM_DUMP_BASE);
                        mem_left  <= CNT_W'(MEM_DUMP_DEPTH);
                        reg_idx   <= '0;
                        dump_busy <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                        acc       <= '0;
`endif
                    end
                end
                READ: begin
                    if (phase == PH_MEM) begin
                        mem_raddr <= mem_idx;
                    end else if (phase == PH_REG) begin
                        reg_raddr <= reg_idx;
                    end
                end
                WAIT: begin
                    dump.valid <= 1'b1;
                    case (phase)
                        PH_MEM: begin
                            dump.kind  <= 1'b0;
                            dump.index <= mem_idx;
                            dump.data  <= mem_rdata;
                            dump.last  <= 1'b0;
                        end
                        PH_REG: begin
                            dump.kind  <= 1'b1;
                            dump.index <= MEM_ADDR_W'(reg_idx);
                            dump.data  <= reg_rdata;
`ifdef DUMP_CHECKSUM_EN
                            dump.last  <= 1'b0;
`else
                            dump.last  <= (reg_idx == REG_LAST);
`endif
                        end
`ifdef DUMP_CHECKSUM_EN
                        PH_CSUM: begin
                            dump.kind  <= 1'b1;
                            dump.index <= '1;
                            dump.data  <= acc;
                            dump.last  <= 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
                EMIT: begin
                    if (hs) begin
                        dump.valid <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
                        acc <= acc + dump.data;
`endif
                        if (dump.last) begin
                            dump_busy <= 1'b0;
                            dump_done <= 1'b1;
                        end else if (phase == PH_MEM) begin
                            // Address wraps naturally at 2^MEM_ADDR_W.
                            mem_idx  <= mem_idx + MEM_ADDR_W'(1);
                            mem_left <= mem_left - CNT_W'(1);
                            if (mem_left == CNT_W'(1)) begin
                                phase   <= PH_REG;
                                reg_idx <= '0;
                            end
                        end else begin
`ifdef DUMP_CHECKSUM_EN
                            if (reg_idx == REG_LAST) begin
                                phase <= PH_CSUM;
                            end else begin
                                reg_idx <= reg_idx + REG_ADDR_W'(1);
                            end
`else
                            reg_idx <= reg_idx + REG_ADDR_W'(1);
`endif
                        end
                    end
                end
                DONE: begin
                    if (do_halt) dump_done <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
